vppm_mac_acc: RTL and testbench

- Parametrised, pipelined multiply-accumulate for the VPPM receiver correlator and filter paths.
- Each operand carries its own signedness mode, so unsigned sample data times signed coefficients (and any other mix) always produces the arithmetically correct signed product.
- Accumulates products over a frame delimited by in_last, then publishes a saturated signed sum with a sample count and an overflow flag.

---
 rtl/vppm_arith_pkg.sv | 39 +++
 rtl/vppm_mode_mult.sv | 62 ++++++
 rtl/vppm_mac_acc.sv | 116 +++++++++++
 tb/tb_vppm_mac_acc.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vppm_arith_pkg.sv
// Shared arithmetic helpers for the VPPM receiver datapaths: per-operand
// signedness extension and saturation bounds for signed accumulators.
package vppm_arith_pkg;

  localparam int A_W_DEF   = 12;
  localparam int B_W_DEF   = 12;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam int MAX_W     = 64;

  // Returns value (whose meaningful bits are [width-1:0]) extended by one bit,
  // as a signed quantity; callers narrow the result to width+1 bits.
  function automatic logic signed [MAX_W:0] sx_mode(input logic [MAX_W-1:0] value,
                                                    input int unsigned width,
                                                    input logic is_signed);
    logic signed [MAX_W:0] r;
    r = {1'b0, value};
    if (is_signed && value[width-1])
      r = r | ({(MAX_W+1){1'b1}} << width);
    return r;
  endfunction

  function automatic logic signed [MAX_W:0] sat_max(input int unsigned w);
    logic signed [MAX_W:0] r;
    r = '0;
    for (int i = 0; i < MAX_W + 1; i++)
      if (i < int'(w) - 1) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic signed [MAX_W:0] sat_min(input int unsigned w);
    logic signed [MAX_W:0] r;
    r = '1;
    for (int i = 0; i < MAX_W + 1; i++)
      if (i < int'(w) - 1) r[i] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/vppm_mode_mult.sv
// Two-stage mode-aware multiplier: stage 1 extends each operand by its own
// signedness mode, stage 2 forms the fully signed product.
module vppm_mode_mult
  import vppm_arith_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [A_W-1:0]           a,
  input  logic [B_W-1:0]           b,
  input  logic                     a_signed,
  input  logic                     b_signed,
  output logic                     valid_o,
  output logic                     last_o,
  output logic signed [A_W+B_W+1:0] prod_o
);

  localparam int P_W = A_W + B_W + 2;

  logic               v1_q, l1_q, v2_q, l2_q;
  logic signed [A_W:0] ea_d, ea_q;
  logic signed [B_W:0] eb_d, eb_q;
  logic signed [P_W-1:0] p_d, p_q;

  always_comb begin
    ea_d = (A_W+1)'(sx_mode(MAX_W'(a), A_W, a_signed));
    eb_d = (B_W+1)'(sx_mode(MAX_W'(b), B_W, b_signed));
    // Both factors are signed and widened first so no unsigned operand ever
    // reaches the multiplier.
    p_d  = P_W'(ea_q) * P_W'(eb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      ea_q <= '0;
      eb_q <= '0;
      v2_q <= 1'b0;
      l2_q <= 1'b0;
      p_q  <= '0;
    end else begin
      v1_q <= in_valid & ~clr;
      l1_q <= in_last;
      ea_q <= ea_d;
      eb_q <= eb_d;
      v2_q <= v1_q & ~clr;
      l2_q <= l1_q;
      p_q  <= p_d;
    end
  end

  assign valid_o = v2_q;
  assign last_o  = l2_q;
  assign prod_o  = p_q;

endmodule

// File: rtl/vppm_mac_acc.sv
// Pipelined multiply-accumulate with per-frame saturated sum, sample count and
// sticky overflow flag, published one cycle after the frame's last product.
module vppm_mac_acc
  import vppm_arith_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam int P_W = A_W + B_W + 2;
  localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] SUM_MIN = (ACC_W+1)'(sat_min(ACC_W));

  generate
    if (ACC_W < A_W + B_W + 2) begin : g_width_check
      $error("vppm_mac_acc: ACC_W must be >= A_W+B_W+2");
    end
  endgenerate

  logic                  p_valid, p_last;
  logic signed [P_W-1:0] p;

  vppm_mode_mult #(.A_W(A_W), .B_W(B_W)) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_last  (in_last),
    .a        (a),
    .b        (b),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .valid_o  (p_valid),
    .last_o   (p_last),
    .prod_o   (p)
  );

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, clamp_hit;
  logic signed [ACC_W:0]   sum;
  logic                    out_valid_q, out_sat_q;
  logic [ACC_W-1:0]        out_acc_q;
  logic [CNT_W-1:0]        out_count_q;

  always_comb begin
    sum       = (ACC_W+1)'(acc_q) + (ACC_W+1)'(p);
    clamp_hit = 1'b0;
    acc_d     = sum[ACC_W-1:0];
    if (sum > SUM_MAX) begin
      acc_d     = SUM_MAX[ACC_W-1:0];
      clamp_hit = 1'b1;
    end else if (sum < SUM_MIN) begin
      acc_d     = SUM_MIN[ACC_W-1:0];
      clamp_hit = 1'b1;
    end
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  // clr takes priority over a product arriving in the same cycle, so a frame
  // in flight is discarded without a publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (clr) begin
        acc_q <= '0;
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (p_valid) begin
        if (p_last) begin
          out_valid_q <= 1'b1;
          out_acc_q   <= acc_d;
          out_count_q <= cnt_d;
          out_sat_q   <= sat_q | clamp_hit;
          acc_q       <= '0;
          cnt_q       <= '0;
          sat_q       <= 1'b0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          sat_q <= sat_q | clamp_hit;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_vppm_mac_acc.sv
// Bench for vppm_mac_acc: a 32-bit and a 26-bit accumulator share stimulus and
// are scored against an arithmetic frame model; directed cases pin known sums.
module tb_vppm_mac_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr, in_valid, in_last, a_signed, b_signed;
  logic [11:0] a, b;

  logic        out_valid32, out_sat32;
  logic [31:0] out_acc32;
  logic [15:0] out_count32;
  logic        out_valid26, out_sat26;
  logic [25:0] out_acc26;
  logic [15:0] out_count26;

  vppm_mac_acc dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid32), .out_acc(out_acc32), .out_count(out_count32), .out_sat(out_sat32)
  );

  vppm_mac_acc #(.ACC_W(26)) dut26 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid26), .out_acc(out_acc26), .out_count(out_count26), .out_sat(out_sat26)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulses32 = 0;
  int pulses26 = 0;

  // Expected frames packed as {sat, count, acc}.
  logic [48:0] exp32_q[$];
  logic [42:0] exp26_q[$];

  longint m_acc32, m_acc26;
  int     m_cnt;
  bit     m_sat32, m_sat26;

  function automatic longint opval(input logic [11:0] v, input logic s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint clampw(input longint s, input int w, output bit hit);
    longint hi, lo;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    hit = 1'b0;
    if (s > hi) begin hit = 1'b1; return hi; end
    if (s < lo) begin hit = 1'b1; return lo; end
    return s;
  endfunction

  task automatic model_clear();
    m_acc32 = 0; m_acc26 = 0; m_cnt = 0; m_sat32 = 0; m_sat26 = 0;
  endtask

  task automatic model_sample(input logic [11:0] va, input logic [11:0] vb,
                              input logic sa, input logic sb, input logic last);
    longint p;
    bit h32, h26;
    p       = opval(va, sa) * opval(vb, sb);
    m_acc32 = clampw(m_acc32 + p, 32, h32);
    m_acc26 = clampw(m_acc26 + p, 26, h26);
    m_sat32 = m_sat32 | h32;
    m_sat26 = m_sat26 | h26;
    m_cnt   = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
    if (last) begin
      exp32_q.push_back({m_sat32, 16'(m_cnt), 32'(m_acc32)});
      exp26_q.push_back({m_sat26, 16'(m_cnt), 26'(m_acc26)});
      model_clear();
    end
  endtask

  task automatic send(input logic [11:0] va, input logic [11:0] vb,
                      input logic sa, input logic sb, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_last = last; a = va; b = vb; a_signed = sa; b_signed = sb;
    model_sample(va, vb, sa, sb, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  // Counts edges after the last driven sample until out_valid is seen.
  task automatic wait_pulse(input int max_cyc, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (out_valid32) begin lat = i; break; end
    end
  endtask

  always @(posedge clk) begin : mon32
    logic [48:0] e;
    #1;
    if (out_valid32) begin
      pulses32++;
      n_tests++;
      if (exp32_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon32_unexpected acc=%0d count=%0d sat=%0b required=no pulse",
                 $signed(out_acc32), out_count32, out_sat32);
      end else begin
        e = exp32_q.pop_front();
        if ({out_sat32, out_count32, out_acc32} !== e) begin
          n_fail++;
          $display("FAIL mon32_frame acc=%0d count=%0d sat=%0b required acc=%0d count=%0d sat=%0b",
                   $signed(out_acc32), out_count32, out_sat32, $signed(e[31:0]), e[47:32], e[48]);
        end
      end
    end
  end

  always @(posedge clk) begin : mon26
    logic [42:0] e;
    #1;
    if (out_valid26) begin
      pulses26++;
      n_tests++;
      if (exp26_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon26_unexpected acc=%0d count=%0d sat=%0b required=no pulse",
                 $signed(out_acc26), out_count26, out_sat26);
      end else begin
        e = exp26_q.pop_front();
        if ({out_sat26, out_count26, out_acc26} !== e) begin
          n_fail++;
          $display("FAIL mon26_frame acc=%0d count=%0d sat=%0b required acc=%0d count=%0d sat=%0b",
                   $signed(out_acc26), out_count26, out_sat26, $signed(e[25:0]), e[41:26], e[42]);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid32, out_acc32, out_count32, out_sat32} !== '0) begin
      n_fail++;
      $display("FAIL reset32 got v=%0b acc=%0d cnt=%0d sat=%0b required all 0",
               out_valid32, out_acc32, out_count32, out_sat32);
    end
    n_tests++;
    if ({out_valid26, out_acc26, out_count26, out_sat26} !== '0) begin
      n_fail++;
      $display("FAIL reset26 got v=%0b acc=%0d cnt=%0d sat=%0b required all 0",
               out_valid26, out_acc26, out_count26, out_sat26);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_signed_mix();
    int lat;
    logic [31:0] e_acc;
    e_acc = -32'sd40000;
    send(12'd200, 12'hF38, 1'b0, 1'b1, 1'b1);
    wait_pulse(8, lat);
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL mix_latency got %0d required 3", lat);
    end
    n_tests++;
    if ({out_acc32, out_count32, out_sat32} !== {e_acc, 16'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL mix_result acc=%0d cnt=%0d sat=%0b required acc=-40000 cnt=1 sat=0",
               $signed(out_acc32), out_count32, out_sat32);
    end
    idle(2);
  endtask

  task automatic test_modes();
    int lat;
    send(12'hF38, 12'hF38, 1'b0, 1'b0, 1'b1);
    wait_pulse(8, lat);
    n_tests++;
    if (lat != 3 || out_acc32 !== 32'd15178816) begin
      n_fail++;
      $display("FAIL modes_unsigned acc=%0d lat=%0d required acc=15178816 lat=3",
               $signed(out_acc32), lat);
    end
    idle(2);
    send(12'hF38, 12'hF38, 1'b1, 1'b1, 1'b1);
    wait_pulse(8, lat);
    n_tests++;
    if (lat != 3 || out_acc32 !== 32'd40000) begin
      n_fail++;
      $display("FAIL modes_signed acc=%0d lat=%0d required acc=40000 lat=3",
               $signed(out_acc32), lat);
    end
    idle(2);
  endtask

  task automatic test_frame_bubble();
    int lat, p0;
    p0 = pulses32;
    send(12'd3, -12'sd5, 1'b1, 1'b1, 1'b0);
    send(-12'sd7, 12'd2, 1'b1, 1'b1, 1'b0);
    idle(1);
    send(12'd100, 12'd100, 1'b1, 1'b1, 1'b0);
    send(-12'sd1, -12'sd1, 1'b1, 1'b1, 1'b1);
    wait_pulse(8, lat);
    n_tests++;
    if ({out_acc32, out_count32, out_sat32} !== {32'd9972, 16'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL frame4_result acc=%0d cnt=%0d sat=%0b required acc=9972 cnt=4 sat=0",
               $signed(out_acc32), out_count32, out_sat32);
    end
    idle(5);
    n_tests++;
    if (pulses32 - p0 != 1) begin
      n_fail++;
      $display("FAIL frame4_pulses got %0d required 1", pulses32 - p0);
    end
  endtask

  task automatic test_sat26();
    int lat;
    send(12'd4095, 12'd4095, 1'b0, 1'b0, 1'b0);
    send(12'd4095, 12'd4095, 1'b0, 1'b0, 1'b0);
    send(12'd4095, 12'd4095, 1'b0, 1'b0, 1'b1);
    wait_pulse(8, lat);
    n_tests++;
    if ({out_acc26, out_count26, out_sat26} !== {26'd33554431, 16'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL sat26_clamp acc=%0d cnt=%0d sat=%0b required acc=33554431 cnt=3 sat=1",
               out_acc26, out_count26, out_sat26);
    end
    n_tests++;
    if ({out_acc32, out_sat32} !== {32'd50307075, 1'b0}) begin
      n_fail++;
      $display("FAIL sat26_wide32 acc=%0d sat=%0b required acc=50307075 sat=0",
               $signed(out_acc32), out_sat32);
    end
    idle(2);
    send(12'd1, 12'd1, 1'b0, 1'b0, 1'b1);
    wait_pulse(8, lat);
    n_tests++;
    if ({out_acc26, out_count26, out_sat26} !== {26'd1, 16'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL sat26_next acc=%0d cnt=%0d sat=%0b required acc=1 cnt=1 sat=0",
               out_acc26, out_count26, out_sat26);
    end
    idle(2);
  endtask

  task automatic test_clr();
    int lat, p0;
    p0 = pulses32;
    send(12'd50, 12'd60, 1'b0, 1'b0, 1'b0);
    send(12'd70, 12'd80, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_last = 1'b1; a = 12'd9; b = 12'd9;
    model_clear();
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    idle(4);
    n_tests++;
    if (pulses32 != p0 || out_acc32 !== 32'd1) begin
      n_fail++;
      $display("FAIL clr_discard pulses=%0d acc=%0d required pulses=0 acc held at 1",
               pulses32 - p0, $signed(out_acc32));
    end
    send(12'd2, 12'd3, 1'b0, 1'b0, 1'b1);
    wait_pulse(8, lat);
    n_tests++;
    if ({out_acc32, out_count32, out_sat32} !== {32'd6, 16'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_next acc=%0d cnt=%0d sat=%0b required acc=6 cnt=1 sat=0",
               $signed(out_acc32), out_count32, out_sat32);
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    int lat, p0;
    send(12'd11, 12'd13, 1'b0, 1'b0, 1'b0);
    send(12'd17, 12'd19, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if ({out_valid32, out_acc32, out_count32, out_sat32,
         out_valid26, out_acc26, out_count26, out_sat26} !== '0) begin
      n_fail++;
      $display("FAIL async_reset acc32=%0d cnt32=%0d acc26=%0d cnt26=%0d required all 0",
               out_acc32, out_count32, out_acc26, out_count26);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses32;
    idle(6);
    n_tests++;
    if (pulses32 != p0) begin
      n_fail++;
      $display("FAIL async_no_pulse got %0d pulses required 0", pulses32 - p0);
    end
    send(12'd5, -12'sd3, 1'b0, 1'b1, 1'b1);
    wait_pulse(8, lat);
    n_tests++;
    if ({out_acc32, out_count32} !== {-32'sd15, 16'd1}) begin
      n_fail++;
      $display("FAIL async_next acc=%0d cnt=%0d required acc=-15 cnt=1",
               $signed(out_acc32), out_count32);
    end
    idle(2);
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int s = 0; s < len; s++) begin
        send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (s == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(8);
  endtask

  task automatic test_drain();
    n_tests++;
    if (exp32_q.size() != 0 || exp26_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_pending got %0d/%0d frames required 0/0",
               exp32_q.size(), exp26_q.size());
    end
    n_tests++;
    if (pulses32 != pulses26) begin
      n_fail++;
      $display("FAIL drain_pulse_match got %0d vs %0d required equal", pulses32, pulses26);
    end
  endtask

  initial begin
    test_reset();
    test_signed_mix();
    test_modes();
    test_frame_bubble();
    test_sat26();
    test_clr();
    test_async_reset();
    test_random();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
